// File: rtl/ram_capture_ctrl_pkg.sv
// Shared definitions for the BlockRAM capture controller: FSM state encoding
// and the address-width helper used to size the BlockRAM ports.
package ram_capture_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Number of bits needed to represent the value 'depth' (BlockRAM-style clogb2).
  function automatic int clogb2(input int depth);
    int result;
    result = 0;
    for (int d = depth; d > 0; d = d >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ram_capture_ctrl.sv
// Capture controller for the BlockRAM sample buffer: records RAM_DEPTH valid
// samples after a start pulse, then serves single-word readbacks.
module ram_capture_ctrl
  import ram_capture_ctrl_pkg::*;
#(
  parameter  int RAM_WIDTH = 32,
  parameter  int RAM_DEPTH = 32,
  localparam int ADDR_W    = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clock,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic                 i_valid,
  input  logic [RAM_WIDTH-1:0] i_data,
  input  logic                 i_rd_req,
  input  logic [ADDR_W-1:0]    i_rd_addr,
  input  logic [RAM_WIDTH-1:0] i_ram_data,
  output logic [ADDR_W-1:0]    o_wr_addr,
  output logic [RAM_WIDTH-1:0] o_wr_data,
  output logic                 o_wr_en,
  output logic [ADDR_W-1:0]    o_rd_addr,
  output logic                 o_rd_en,
  output logic [RAM_WIDTH-1:0] o_rd_data,
  output logic                 o_rd_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ADDR_W:0]      o_count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(RAM_DEPTH);
  localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W + 1)'(RAM_DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_CNT   = (ADDR_W + 1)'(1);

  state_t                 r_state;
  logic [ADDR_W:0]        r_count;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_rd_valid;
  logic                   r_rd_oob;
  logic [RAM_WIDTH-1:0]   r_rd_hold;

  logic                   w_capture;
  logic                   w_readable;
  logic                   w_rd_accept;
  logic                   w_addr_ok;
  logic                   w_wr_en;
  logic                   w_last;
  logic [RAM_WIDTH-1:0]   w_rd_word;

  // The write pointer is the low bits of the word count; the count keeps one
  // extra bit so a full buffer reads as RAM_DEPTH rather than wrapping to 0.
  assign w_capture   = (r_state == ST_CAPTURE);
  assign w_readable  = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_rd_accept = i_rd_req && w_readable && !i_start && !i_reset;
  assign w_addr_ok   = ({1'b0, i_rd_addr} < DEPTH_CNT);
  assign w_wr_en     = w_capture && i_valid && !i_reset;
  assign w_last      = (r_count == LAST_CNT);
  assign w_rd_word   = r_rd_oob ? '0 : i_ram_data;

  assign o_wr_en    = w_wr_en;
  assign o_wr_addr  = w_wr_en ? r_count[ADDR_W-1:0] : '0;
  assign o_wr_data  = w_wr_en ? i_data : '0;
  assign o_rd_en    = w_rd_accept && w_addr_ok;
  assign o_rd_addr  = (w_rd_accept && w_addr_ok) ? i_rd_addr : '0;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_valid ? w_rd_word : r_rd_hold;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_count    = r_count;

  // Readback data comes straight from the RAM output register during the
  // strobe cycle and is latched locally so it stays stable afterwards.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_oob   <= 1'b0;
      r_rd_hold  <= '0;
    end else begin
      r_rd_valid <= w_rd_accept;
      r_rd_oob   <= !w_addr_ok;
      if (r_rd_valid) begin
        r_rd_hold <= w_rd_word;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_state <= ST_CAPTURE;
            r_count <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (i_valid) begin
            r_count <= r_count + ONE_CNT;
            if (w_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_capture_ctrl.sv
// Bench: ram_capture_ctrl next to a LOW_LATENCY BlockRAM model, checked
// against an array model of what the buffer should hold.
module tb_ram_capture_ctrl;

  localparam int W = 32;
  localparam int D = 32;
  localparam int AW = 5;

  logic          clock;
  logic          i_reset, i_start, i_valid, i_rd_req;
  logic [W-1:0]  i_data, i_ram_data;
  logic [AW-1:0] i_rd_addr;
  logic [AW-1:0] o_wr_addr, o_rd_addr;
  logic [W-1:0]  o_wr_data, o_rd_data;
  logic          o_wr_en, o_rd_en, o_rd_valid, o_busy, o_done;
  logic [AW:0]   o_count;

  int n_checks = 0;
  int n_fail = 0;
  int viol = 0;

  logic [W-1:0] ram [D];
  logic [W-1:0] ref_mem [D];

  ram_capture_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clock(clock), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid),
    .i_data(i_data), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .i_ram_data(i_ram_data), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_wr_en(o_wr_en), .o_rd_addr(o_rd_addr), .o_rd_en(o_rd_en),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_busy(o_busy),
    .o_done(o_done), .o_count(o_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // BlockRAM, LOW_LATENCY: write-first not needed, output registered on read enable.
  always @(posedge clock) begin
    if (o_wr_en) ram[o_wr_addr] <= o_wr_data;
    if (o_rd_en) i_ram_data <= ram[o_rd_addr];
  end

  // Writes only while capturing, never alongside a read.
  always @(negedge clock) begin
    if (i_reset === 1'b0 && o_wr_en === 1'b1 && o_busy !== 1'b1) viol++;
    if (o_wr_en === 1'b1 && o_rd_en === 1'b1) viol++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic read_word(input logic [AW-1:0] a, output logic en,
                           output logic valid, output logic [W-1:0] data);
    i_rd_req = 1'b1;
    i_rd_addr = a;
    #1;
    en = o_rd_en;
    tick();
    i_rd_req = 1'b0;
    valid = o_rd_valid;
    data = o_rd_data;
  endtask

  // Drives one capture; vmode 0 = always valid with data base+n,
  // 1 = valid on odd cycles, 2 = random valid. Model array updated per accepted sample.
  task automatic capture_stream(input int vmode, input logic [W-1:0] base,
                                input int start_at, input int rd_at, input int reset_at,
                                output int cyc, output int busy_cyc,
                                output int wr_errs, output int rd_seen);
    int n;
    logic v, rst, exp_en;
    logic [W-1:0] d;
    n = 0; cyc = 0; busy_cyc = 0; wr_errs = 0; rd_seen = 0;
    rst = 1'b0;
    while (n < D && cyc < 300 && !rst) begin
      case (vmode)
        0: v = 1'b1;
        1: v = (cyc % 2) == 1;
        default: v = 1'($urandom_range(0, 1));
      endcase
      d = (vmode == 0) ? base + W'(n) : $urandom;
      rst = (n == reset_at);
      i_valid = v;
      i_data = d;
      i_start = (n == start_at);
      i_rd_req = (n == rd_at);
      i_rd_addr = AW'($urandom_range(0, D - 1));
      i_reset = rst;
      #1;
      exp_en = v && !rst;
      if (o_busy === 1'b1) busy_cyc++;
      if (o_wr_en !== exp_en) wr_errs++;
      else if (exp_en && (o_wr_addr !== AW'(n) || o_wr_data !== d)) wr_errs++;
      if (o_rd_en !== 1'b0) rd_seen++;
      tick();
      if (o_rd_valid !== 1'b0) rd_seen++;
      cyc++;
      if (exp_en) begin
        ref_mem[n] = d;
        n++;
      end
    end
    i_valid = 1'b0; i_start = 1'b0; i_rd_req = 1'b0; i_reset = 1'b0;
    i_data = '0;
  endtask

  task automatic test_reset();
    logic en, valid;
    logic [W-1:0] data;
    logic [AW-1:0] a;
    i_reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({o_busy, o_done, o_wr_en, o_rd_en, o_rd_valid} !== 5'b0 || o_count !== '0 ||
        o_wr_addr !== '0 || o_rd_addr !== '0 || o_wr_data !== '0 || o_rd_data !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got busy=%b done=%b wen=%b ren=%b rv=%b cnt=%0d rd=%h expected all 0",
               o_busy, o_done, o_wr_en, o_rd_en, o_rd_valid, o_count, o_rd_data);
    end
    i_reset = 1'b0;
    tick();
    a = AW'($urandom_range(0, D - 1));
    read_word(a, en, valid, data);
    n_checks++;
    if (en !== 1'b1 || valid !== 1'b1 || data !== ref_mem[a]) begin
      n_fail++;
      $display("[TB] FAIL reset_readback: got en=%b valid=%b data=%h expected 1 1 %h", en, valid, data, ref_mem[a]);
    end
  endtask

  task automatic test_full_capture();
    int cyc, busy_cyc, wr_errs, rd_seen;
    logic en, valid;
    logic [W-1:0] data;
    pulse_start();
    capture_stream(0, 32'h100, -1, -1, -1, cyc, busy_cyc, wr_errs, rd_seen);
    n_checks++;
    if (busy_cyc !== 32 || o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_busy: got %0d cycles busy_now=%b expected 32 cycles busy_now=0", busy_cyc, o_busy);
    end
    n_checks++;
    if (wr_errs !== 0) begin
      n_fail++;
      $display("[TB] FAIL full_writes: got %0d bad write cycles expected 0", wr_errs);
    end
    n_checks++;
    if (o_done !== 1'b1 || o_count !== 6'd32) begin
      n_fail++;
      $display("[TB] FAIL full_done: got done=%b count=%0d expected 1 32", o_done, o_count);
    end
    read_word(5'd0, en, valid, data);
    n_checks++;
    if (valid !== 1'b1 || data !== 32'h100) begin
      n_fail++;
      $display("[TB] FAIL full_read0: got valid=%b data=%h expected 1 00000100", valid, data);
    end
    read_word(5'd31, en, valid, data);
    n_checks++;
    if (valid !== 1'b1 || data !== 32'h11F) begin
      n_fail++;
      $display("[TB] FAIL full_read31: got valid=%b data=%h expected 1 0000011f", valid, data);
    end
  endtask

  task automatic test_sparse_valid();
    int cyc, busy_cyc, wr_errs, rd_seen;
    logic en, valid;
    logic [W-1:0] data;
    pulse_start();
    capture_stream(1, '0, -1, -1, -1, cyc, busy_cyc, wr_errs, rd_seen);
    n_checks++;
    if (busy_cyc !== 64 || wr_errs !== 0 || o_count !== 6'd32 || o_done !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL sparse_capture: got busy=%0d wr_errs=%0d count=%0d done=%b expected 64 0 32 1",
               busy_cyc, wr_errs, o_count, o_done);
    end
    for (int a = 0; a < D; a++) begin
      read_word(AW'(a), en, valid, data);
      n_checks++;
      if (en !== 1'b1 || valid !== 1'b1 || data !== ref_mem[a]) begin
        n_fail++;
        $display("[TB] FAIL sparse_read[%0d]: got en=%b valid=%b data=%h expected 1 1 %h", a, en, valid, data, ref_mem[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      i_rd_req = 1'b1;
      i_rd_addr = AW'(5 + k);
      #1;
      n_checks++;
      if (o_rd_en !== 1'b1 || o_rd_addr !== AW'(5 + k)) begin
        n_fail++;
        $display("[TB] FAIL b2b_req[%0d]: got en=%b addr=%0d expected 1 %0d", k, o_rd_en, o_rd_addr, 5 + k);
      end
      tick();
      n_checks++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== ref_mem[5 + k]) begin
        n_fail++;
        $display("[TB] FAIL b2b_data[%0d]: got valid=%b data=%h expected 1 %h", k, o_rd_valid, o_rd_data, ref_mem[5 + k]);
      end
    end
    i_rd_req = 1'b0;
    tick();
    n_checks++;
    if (o_rd_valid !== 1'b0 || o_rd_data !== ref_mem[7]) begin
      n_fail++;
      $display("[TB] FAIL b2b_hold: got valid=%b data=%h expected 0 %h", o_rd_valid, o_rd_data, ref_mem[7]);
    end
  endtask

  task automatic test_start_ignored();
    int cyc, busy_cyc, wr_errs, rd_seen;
    pulse_start();
    capture_stream(2, '0, 10, 5, -1, cyc, busy_cyc, wr_errs, rd_seen);
    n_checks++;
    if (busy_cyc !== cyc || wr_errs !== 0 || o_count !== 6'd32 || o_done !== 1'b1 || o_busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL restart_ignored: got busy=%0d wr_errs=%0d count=%0d done=%b expected %0d 0 32 1",
               busy_cyc, wr_errs, o_count, o_done, cyc);
    end
    n_checks++;
    if (rd_seen !== 0) begin
      n_fail++;
      $display("[TB] FAIL capture_read_dropped: got %0d read events expected 0", rd_seen);
    end
  endtask

  task automatic test_reset_mid_capture();
    int cyc, busy_cyc, wr_errs, rd_seen;
    logic en, valid;
    logic [W-1:0] data;
    pulse_start();
    capture_stream(0, 32'h200, -1, -1, 16, cyc, busy_cyc, wr_errs, rd_seen);
    n_checks++;
    if (o_count !== '0 || o_busy !== 1'b0 || o_done !== 1'b0 || wr_errs !== 0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_state: got count=%0d busy=%b done=%b wr_errs=%0d expected 0 0 0 0",
               o_count, o_busy, o_done, wr_errs);
    end
    for (int a = 0; a < D; a++) begin
      read_word(AW'(a), en, valid, data);
      n_checks++;
      if (valid !== 1'b1 || data !== ref_mem[a] || (a < 16 && data !== 32'h200 + W'(a))) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_read[%0d]: got valid=%b data=%h expected 1 %h", a, valid, data, ref_mem[a]);
      end
    end
    i_start = 1'b1;
    i_rd_req = 1'b1;
    i_rd_addr = 5'd3;
    #1;
    n_checks++;
    if (o_rd_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL start_vs_read_en: got %b expected 0", o_rd_en);
    end
    tick();
    i_start = 1'b0;
    i_rd_req = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_rd_valid !== 1'b0 || o_count !== '0) begin
      n_fail++;
      $display("[TB] FAIL start_vs_read: got busy=%b rd_valid=%b count=%0d expected 1 0 0", o_busy, o_rd_valid, o_count);
    end
    capture_stream(2, '0, -1, -1, -1, cyc, busy_cyc, wr_errs, rd_seen);
    n_checks++;
    if (o_done !== 1'b1 || o_count !== 6'd32 || wr_errs !== 0) begin
      n_fail++;
      $display("[TB] FAIL post_start_capture: got done=%b count=%0d wr_errs=%0d expected 1 32 0", o_done, o_count, wr_errs);
    end
  endtask

  task automatic test_protocol();
    n_checks++;
    if (viol !== 0) begin
      n_fail++;
      $display("[TB] FAIL write_read_protocol: got %0d violations expected 0", viol);
    end
  endtask

  initial begin
    i_reset = 1'b0; i_start = 1'b0; i_valid = 1'b0; i_rd_req = 1'b0;
    i_data = '0; i_rd_addr = '0; i_ram_data = '0;
    for (int a = 0; a < D; a++) begin
      ram[a] = $urandom;
      ref_mem[a] = ram[a];
    end
    test_reset();
    test_full_capture();
    test_sparse_valid();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_capture();
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
